// File: rtl/if_id_skid_stage_pkg.sv
// Shared core types for the IF->ID stage: default widths, the NOP encoding, the entry struct and the skid FSM states.
package core_pkg;
  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} skid_state_t;
endpackage

// File: rtl/if_id_skid_stage_if.sv
// IF->ID handshake bundle: the fetch-side valid/ready/data, the decode-side valid/ready/data, and the redirect flush.
// master drives fetch data, decode ready and flush; slave is the pipeline stage.
interface if_id_skid_stage_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/if_id_skid_stage_entry_reg.sv
// pipe_entry_reg: one if_id_t register, loaded on load, returned to {pc=0, instr=CLR_INSTR} by clear or async reset.
// Latency 1 cycle from load to q; no backpressure of its own, clear wins over load.
module pipe_entry_reg
  import core_pkg::*;
#(
  parameter logic [31:0] CLR_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '{pc: 32'h0, instr: CLR_INSTR};
    end else if (clear) begin
      q <= '{pc: 32'h0, instr: CLR_INSTR};
    end else if (load) begin
      q <= d;
    end
  end
endmodule

// File: rtl/if_id_skid_stage.sv
// Registered IF->ID stage with a two-entry skid buffer; 1 cycle latency when empty, in_ready is a flop (low only while skid holds an entry).
// Optional macro IF_ID_STALL_CNT_EN adds a saturating stall_cnt of cycles where decode held off a valid entry.
module if_id_skid_stage
  import core_pkg::*;
#(
  parameter int          XLEN      = XLEN_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  if_id_skid_stage_if.slave  bus
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);
  skid_state_t state, state_nxt;
  logic        out_valid_q;
  logic        in_ready_q;
  logic        in_fire;
  logic        out_fire;
  if_id_t      in_ent;
  if_id_t      main_d;
  if_id_t      main_q;
  if_id_t      skid_q;
  logic        main_load;
  logic        skid_load;
  logic        skid_clear;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;
  assign in_ent   = '{pc: bus.in_pc, instr: bus.in_instr};

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (in_fire) state_nxt = S_FULL;
        S_FULL: begin
          if (in_fire && !out_fire)      state_nxt = S_SKID;
          else if (!in_fire && out_fire) state_nxt = S_EMPTY;
        end
        S_SKID:  if (out_fire) state_nxt = S_FULL;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // Handshake flags are registered alongside the state so neither output has logic behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state       <= state_nxt;
      out_valid_q <= (state_nxt != S_EMPTY);
      in_ready_q  <= (state_nxt != S_SKID);
    end
  end

  assign main_load  = (state == S_EMPTY && in_fire) ||
                      (state == S_FULL  && in_fire && out_fire) ||
                      (state == S_SKID  && out_fire);
  assign main_d     = (state == S_SKID) ? skid_q : in_ent;
  assign skid_load  = (state == S_FULL) && in_fire && !out_fire;
  assign skid_clear = bus.flush || (state == S_SKID && out_fire);

  pipe_entry_reg #(.CLR_INSTR(NOP_INSTR)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (bus.flush),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_entry_reg #(.CLR_INSTR(32'h0)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_ent),
    .q     (skid_q)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = XLEN'(main_q.pc);
  // After a drain the pc is left in place but decode must see a bubble.
  assign bus.out_instr = out_valid_q ? XLEN'(main_q.instr) : XLEN'(NOP_INSTR);

`ifdef IF_ID_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'h0;
    end else if (out_valid_q && !bus.out_ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'h1;
    end
  end
`endif
endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench for if_id_skid_stage: reset, single entry, streaming, backpressure/skid, flush, async reset, optional stall counter.
module tb_if_id_skid_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_id_skid_stage_if #(.XLEN(32)) bus ();
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  if_id_skid_stage dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = instr;
  endtask

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #2;
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_in_ready",  {31'h0, bus.in_ready},  32'h1);
    check("rst_out_pc",    bus.out_pc,    32'h0);
    check("rst_out_instr", bus.out_instr, 32'h13);
`ifdef IF_ID_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'h0);
`endif
    step();
    reset = 1'b0;

    // single entry
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h100, 32'h0050_0093);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("single_valid", {31'h0, bus.out_valid}, 32'h1);
    check("single_pc",    bus.out_pc,    32'h100);
    check("single_instr", bus.out_instr, 32'h0050_0093);
    step();
    check("single_drain_valid", {31'h0, bus.out_valid}, 32'h0);
    check("single_drain_instr", bus.out_instr, 32'h13);
    check("single_drain_rdy",   {31'h0, bus.in_ready}, 32'h1);

    // back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'h1000 + 32'(i));
      step();
      check($sformatf("stream%0d_valid", i), {31'h0, bus.out_valid}, 32'h1);
      check($sformatf("stream%0d_pc", i),    bus.out_pc,    32'(i * 4));
      check($sformatf("stream%0d_instr", i), bus.out_instr, 32'h1000 + 32'(i));
      check($sformatf("stream%0d_rdy", i),   {31'h0, bus.in_ready}, 32'h1);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    check("stream_end_valid", {31'h0, bus.out_valid}, 32'h0);

    // backpressure: 3 offered, 2 taken, then drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h0, 32'hA0);
    step();
    check("bp_first_pc",  bus.out_pc, 32'h0);
    check("bp_first_rdy", {31'h0, bus.in_ready}, 32'h1);
    drive(1'b1, 32'h4, 32'hA4);
    step();
    check("bp_skid_rdy", {31'h0, bus.in_ready}, 32'h0);
    check("bp_skid_pc",  bus.out_pc,    32'h0);
    drive(1'b1, 32'h8, 32'hA8);
    step();
    check("bp_hold_rdy",   {31'h0, bus.in_ready}, 32'h0);
    check("bp_hold_pc",    bus.out_pc,    32'h0);
    check("bp_hold_instr", bus.out_instr, 32'hA0);
    bus.out_ready = 1'b1;
    step();
    check("bp_out1_pc",    bus.out_pc,    32'h4);
    check("bp_out1_instr", bus.out_instr, 32'hA4);
    check("bp_out1_rdy",   {31'h0, bus.in_ready}, 32'h1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("bp_out2_pc",    bus.out_pc,    32'h8);
    check("bp_out2_instr", bus.out_instr, 32'hA8);
    check("bp_out2_valid", {31'h0, bus.out_valid}, 32'h1);
    step();
    check("bp_empty_valid", {31'h0, bus.out_valid}, 32'h0);

    // flush in SKID with in_valid high
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h20, 32'hB0);
    step();
    drive(1'b1, 32'h24, 32'hB4);
    step();
    check("fl_skid_rdy", {31'h0, bus.in_ready}, 32'h0);
    drive(1'b1, 32'h28, 32'hB8);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl_valid", {31'h0, bus.out_valid}, 32'h0);
    check("fl_instr", bus.out_instr, 32'h13);
    check("fl_pc",    bus.out_pc,    32'h0);
    check("fl_rdy",   {31'h0, bus.in_ready}, 32'h1);
    step();
    check("fl_after_valid", {31'h0, bus.out_valid}, 32'h0);

    // flush in FULL discards a simultaneous in_fire
    drive(1'b1, 32'h30, 32'hC0);
    step();
    drive(1'b1, 32'h34, 32'hC4);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flf_valid", {31'h0, bus.out_valid}, 32'h0);
    check("flf_rdy",   {31'h0, bus.in_ready}, 32'h1);
    step();
    check("flf_after_valid", {31'h0, bus.out_valid}, 32'h0);

    // async reset while in SKID
    drive(1'b1, 32'h40, 32'hD0);
    step();
    drive(1'b1, 32'h44, 32'hD4);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("ar_pre_rdy", {31'h0, bus.in_ready}, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", {31'h0, bus.out_valid}, 32'h0);
    check("ar_rdy",   {31'h0, bus.in_ready},  32'h1);
    check("ar_instr", bus.out_instr, 32'h13);
    check("ar_pc",    bus.out_pc,    32'h0);
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("ar_after_valid", {31'h0, bus.out_valid}, 32'h0);

`ifdef IF_ID_STALL_CNT_EN
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h50, 32'hE0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("sc_start", stall_cnt, 32'h0);
    for (int i = 0; i < 5; i++) step();
    check("sc_five", stall_cnt, 32'h5);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    check("sc_flush", stall_cnt, 32'h5);
    step();
    check("sc_idle", stall_cnt, 32'h5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
